// File: rtl/fw_ldr_pkg.sv
// fw_ldr shared types: command op codes, loader FSM states and
// the default firmware-completion signature.
package fw_ldr_pkg;

  typedef enum logic [1:0] {
    OP_WR  = 2'b00,
    OP_VF  = 2'b01,
    OP_RUN = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADRH,
    S_ADRL,
    S_DATA,
    S_VRD,
    S_VCMP
  } state_e;

  localparam logic [7:0] DONE_SIG_DEF = 8'hEF;

endpackage

// File: rtl/fw_ldr_wdog.sv
// Run supervisor: after release watches port 0 for the completion
// signature and flags done or timeout (both sticky until cleared).
module fw_ldr_wdog
  import fw_ldr_pkg::*;
#(
  parameter int         TO_W     = 16,
  parameter logic [7:0] DONE_SIG = DONE_SIG_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       arm_i,
  input  logic       hold_i,
  input  logic [7:0] port0_i,
  output logic       done_o,
  output logic       timeout_o
);

  logic            arm_q, arm_d;
  logic            done_q, done_d;
  logic            to_q, to_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0] cnt_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_q  <= 1'b0;
      done_q <= 1'b0;
      to_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      arm_q  <= arm_d;
      done_q <= done_d;
      to_q   <= to_d;
      cnt_q  <= cnt_d;
    end
  end

  // Signature check has priority, so done wins over a same-cycle timeout.
  always_comb begin
    arm_d   = arm_q;
    done_d  = done_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 1'b1;
    if (clr_i) begin
      arm_d  = 1'b0;
      done_d = 1'b0;
      to_d   = 1'b0;
      cnt_d  = '0;
    end else if (arm_i) begin
      arm_d = 1'b1;
    end else if (arm_q && !hold_i) begin
      if (port0_i == DONE_SIG) begin
        done_d = 1'b1;
        arm_d  = 1'b0;
      end else begin
        cnt_d = cnt_inc;
        if (&cnt_inc) begin
          to_d  = 1'b1;
          arm_d = 1'b0;
        end
      end
    end
  end

  assign done_o    = done_q;
  assign timeout_o = to_q;

endmodule

// File: rtl/fw_ldr.sv
// Byte-stream firmware loader: framed write/verify into program memory
// banks, CPU fetch hold until RUN, then completion supervision.
module fw_ldr
  import fw_ldr_pkg::*;
#(
  parameter int         AW       = 14,
  parameter int         DW       = 8,
  parameter int         NBANK    = 2,
  parameter int         TO_W     = 16,
  parameter logic [7:0] DONE_SIG = DONE_SIG_DEF,
  localparam int        BW       = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_vld,
  input  logic [7:0]    s_dat,
  input  logic          s_lst,
  output logic          s_rdy,
  output logic          mem_we,
  output logic          mem_re,
  output logic [BW-1:0] mem_bank,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdat,
  input  logic [DW-1:0] mem_rdat,
  output logic          cpu_hold,
  input  logic [7:0]    port0,
  output logic          busy,
  output logic [7:0]    err_cnt,
  output logic          done,
  output logic          timeout
);

  localparam int NB = DW / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  state_e        state_q, state_d;
  logic          vf_q, vf_d;
  logic [BW-1:0] bank_q, bank_d;
  logic [7:0]    adrh_q, adrh_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] asm_q, asm_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic          we_q, we_d;
  logic          lst_q, lst_d;
  logic [7:0]    err_q, err_d;
  logic          hold_q, hold_d;
  logic          rdy_en_q;

  logic          acc;
  logic          re;
  logic          wd_clr;
  logic          wd_arm;
  op_e           op;
  logic [BW-1:0] bsel;
  logic [BW-1:0] bank_c;
  logic [DW-1:0] word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      vf_q     <= 1'b0;
      bank_q   <= '0;
      adrh_q   <= '0;
      adr_q    <= '0;
      asm_q    <= '0;
      bcnt_q   <= '0;
      wdat_q   <= '0;
      we_q     <= 1'b0;
      lst_q    <= 1'b0;
      err_q    <= '0;
      hold_q   <= 1'b1;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vf_q     <= vf_d;
      bank_q   <= bank_d;
      adrh_q   <= adrh_d;
      adr_q    <= adr_d;
      asm_q    <= asm_d;
      bcnt_q   <= bcnt_d;
      wdat_q   <= wdat_d;
      we_q     <= we_d;
      lst_q    <= lst_d;
      err_q    <= err_d;
      hold_q   <= hold_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign s_rdy = rdy_en_q & (state_q inside {S_IDLE, S_ADRH, S_ADRL, S_DATA});
  assign acc   = s_vld & s_rdy;
  assign op    = op_e'(s_dat[7:6]);
  assign bsel  = s_dat[BW-1:0];
  assign bank_c = ({1'b0, bsel} >= (BW+1)'(NBANK)) ? BW'(NBANK - 1) : bsel;
  // New byte enters at the top so the first byte ends up in the LSBs.
  assign word  = DW'({s_dat, asm_q} >> 8);

  always_comb begin
    state_d = state_q;
    vf_d    = vf_q;
    bank_d  = bank_q;
    adrh_d  = adrh_q;
    adr_d   = adr_q;
    asm_d   = asm_q;
    bcnt_d  = bcnt_q;
    wdat_d  = wdat_q;
    we_d    = 1'b0;
    lst_d   = lst_q;
    err_d   = err_q;
    hold_d  = hold_q;
    re      = 1'b0;
    wd_clr  = 1'b0;
    wd_arm  = 1'b0;
    // Address advances in the strobe cycle so it is stable while mem_we is high.
    if (we_q) adr_d = adr_q + 1'b1;
    unique case (state_q)
      S_IDLE: if (acc) begin
        unique case (op)
          OP_WR, OP_VF: begin
            vf_d   = (op == OP_VF);
            bank_d = bank_c;
            hold_d = 1'b1;
            wd_clr = 1'b1;
            if (op == OP_VF) err_d = '0;
            if (!s_lst) state_d = S_ADRH;
          end
          OP_RUN: begin
            hold_d = 1'b0;
            wd_arm = 1'b1;
          end
          default: ;
        endcase
      end
      S_ADRH: if (acc) begin
        adrh_d  = s_dat;
        state_d = s_lst ? S_IDLE : S_ADRL;
      end
      S_ADRL: if (acc) begin
        if (s_lst) begin
          state_d = S_IDLE;
        end else begin
          adr_d   = AW'({adrh_q, s_dat});
          bcnt_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: if (acc) begin
        asm_d = word;
        if (bcnt_q == CW'(NB - 1)) begin
          bcnt_d = '0;
          wdat_d = word;
          lst_d  = s_lst;
          if (vf_q) begin
            state_d = S_VRD;
          end else begin
            we_d = 1'b1;
            if (s_lst) state_d = S_IDLE;
          end
        end else if (s_lst) begin
          bcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      S_VRD: begin
        re      = 1'b1;
        state_d = S_VCMP;
      end
      S_VCMP: begin
        if (mem_rdat != wdat_q && err_q != 8'hFF) err_d = err_q + 1'b1;
        adr_d   = adr_q + 1'b1;
        state_d = lst_q ? S_IDLE : S_DATA;
      end
      default: state_d = S_IDLE;
    endcase
  end

  fw_ldr_wdog #(
    .TO_W    (TO_W),
    .DONE_SIG(DONE_SIG)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wd_clr),
    .arm_i    (wd_arm),
    .hold_i   (hold_q),
    .port0_i  (port0),
    .done_o   (done),
    .timeout_o(timeout)
  );

  assign mem_we   = we_q;
  assign mem_re   = re;
  assign mem_bank = bank_q;
  assign mem_adr  = adr_q;
  assign mem_wdat = wdat_q;
  assign cpu_hold = hold_q;
  assign busy     = (state_q != S_IDLE);
  assign err_cnt  = err_q;

endmodule
